ascon128_enc_ctrl: RTL and testbench

Round-sequencing FSM for the round-based Ascon-128 single-block encryption datapath: one permutation round per cycle, with a shared 320-bit state register.
- Accepts a start request and drives the per-cycle datapath controls: state load, round enable, round-constant index, key/data XOR strobes and output valids.
- Covers initialization, optional associated-data absorb, domain separation, plaintext encryption, finalization and tag release.
- Sits between the top-level request interface and the datapath, which owns the SK/N/A/P inputs and the C/T outputs.

---
 rtl/ascon_ctrl_pkg.sv | 30 +++
 rtl/ascon128_enc_ctrl_round_cnt.sv | 39 +++
 rtl/ascon128_enc_ctrl.sv | 147 ++++++++++++++
 tb/tb_ascon128_enc_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ascon_ctrl_pkg.sv
// Shared definitions for the Ascon-128 encryption round sequencer:
// state encoding, round-count defaults, IV and round-constant helper.
package ascon_ctrl_pkg;

  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 6;
  localparam int RC_W_DEF     = 4;

  localparam logic [63:0] ASCON128_IV = 64'h80400c0600000000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT_LOAD = 4'd1,
    S_INIT_PERM = 4'd2,
    S_INIT_KEY  = 4'd3,
    S_AD_XOR    = 4'd4,
    S_AD_PERM   = 4'd5,
    S_DOMSEP    = 4'd6,
    S_PT_XOR    = 4'd7,
    S_FIN_KEY   = 4'd8,
    S_FIN_PERM  = 4'd9,
    S_TAG       = 4'd10
  } ctrl_state_e;

  // Round constant byte for index i: high nibble 0xF-i, low nibble i.
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

endpackage

// File: rtl/ascon128_enc_ctrl_round_cnt.sv
// Loadable round-index up-counter; stops at LAST and clears to zero instead
// of wrapping, flagging the final round with tc.
module ascon_round_cnt #(
  parameter int RC_W = 4,
  parameter int LAST = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [RC_W-1:0] load_val,
  input  logic            inc,
  output logic [RC_W-1:0] cnt,
  output logic            tc
);

  logic [RC_W-1:0] cnt_q;
  logic [RC_W-1:0] cnt_d;

  assign tc  = (cnt_q == RC_W'(LAST));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ascon128_enc_ctrl.sv
// Round-sequencing FSM for a one-round-per-cycle Ascon-128 single-block
// encryption datapath; all datapath controls are Moore-decoded.
module ascon128_enc_ctrl
  import ascon_ctrl_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF,
  parameter int RC_W     = RC_W_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic            has_ad,
  input  logic            out_ack,
  output logic            ready,
  output logic            busy,
  output logic            st_load,
  output logic            rnd_en,
  output logic [RC_W-1:0] rnd_idx,
  output logic            key_xor_init,
  output logic            ad_xor,
  output logic            dom_sep,
  output logic            pt_xor,
  output logic            c_valid,
  output logic            key_xor_fin,
  output logic            tag_valid
);

  localparam logic [RC_W-1:0] AD_FIRST = RC_W'(ROUNDS_A - ROUNDS_B);

  ctrl_state_e     state_q, state_d;
  logic            has_ad_q, has_ad_d;
  logic            cnt_load, cnt_inc, cnt_tc;
  logic [RC_W-1:0] cnt_load_val, cnt;

  ascon_round_cnt #(
    .RC_W (RC_W),
    .LAST (ROUNDS_A - 1)
  ) u_round_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    has_ad_d     = has_ad_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_INIT_LOAD;
          has_ad_d = has_ad;
        end
      end
      S_INIT_LOAD: begin
        state_d  = S_INIT_PERM;
        cnt_load = 1'b1;
      end
      S_INIT_PERM: begin
        cnt_inc = 1'b1;
        if (cnt_tc) state_d = S_INIT_KEY;
      end
      S_INIT_KEY: state_d = has_ad_q ? S_AD_XOR : S_DOMSEP;
      S_AD_XOR: begin
        state_d      = S_AD_PERM;
        cnt_load     = 1'b1;
        cnt_load_val = AD_FIRST;
      end
      S_AD_PERM: begin
        cnt_inc = 1'b1;
        if (cnt_tc) state_d = S_DOMSEP;
      end
      S_DOMSEP: state_d = S_PT_XOR;
      S_PT_XOR: state_d = S_FIN_KEY;
      S_FIN_KEY: begin
        state_d  = S_FIN_PERM;
        cnt_load = 1'b1;
      end
      S_FIN_PERM: begin
        cnt_inc = 1'b1;
        if (cnt_tc) state_d = S_TAG;
      end
      S_TAG: begin
        if (out_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode depends only on registered state and counter.
  always_comb begin
    ready        = 1'b0;
    busy         = 1'b1;
    st_load      = 1'b0;
    rnd_en       = 1'b0;
    rnd_idx      = '0;
    key_xor_init = 1'b0;
    ad_xor       = 1'b0;
    dom_sep      = 1'b0;
    pt_xor       = 1'b0;
    c_valid      = 1'b0;
    key_xor_fin  = 1'b0;
    tag_valid    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      S_INIT_LOAD: st_load = 1'b1;
      S_INIT_PERM, S_AD_PERM, S_FIN_PERM: begin
        rnd_en  = 1'b1;
        rnd_idx = cnt;
      end
      S_INIT_KEY: key_xor_init = 1'b1;
      S_AD_XOR:   ad_xor       = 1'b1;
      S_DOMSEP:   dom_sep      = 1'b1;
      S_PT_XOR: begin
        pt_xor  = 1'b1;
        c_valid = 1'b1;
      end
      S_FIN_KEY: key_xor_fin = 1'b1;
      S_TAG:     tag_valid   = 1'b1;
      default: begin
        ready = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      has_ad_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      has_ad_q <= has_ad_d;
    end
  end

endmodule

// File: tb/tb_ascon128_enc_ctrl.sv
// Directed bench for the Ascon-128 encryption round sequencer.
module tb_ascon128_enc_ctrl;
  import ascon_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       has_ad = 1'b0;
  logic       out_ack = 1'b0;
  logic       ready, busy, st_load, rnd_en;
  logic [3:0] rnd_idx;
  logic       key_xor_init, ad_xor, dom_sep, pt_xor, c_valid, key_xor_fin, tag_valid;
  logic [14:0] obs;

  int checks = 0;
  int errors = 0;
  int n_rnd, n_ld, n_ad, n_cv, n_tv;

  ascon128_enc_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6), .RC_W(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .has_ad(has_ad), .out_ack(out_ack),
    .ready(ready), .busy(busy), .st_load(st_load), .rnd_en(rnd_en),
    .rnd_idx(rnd_idx), .key_xor_init(key_xor_init), .ad_xor(ad_xor),
    .dom_sep(dom_sep), .pt_xor(pt_xor), .c_valid(c_valid),
    .key_xor_fin(key_xor_fin), .tag_valid(tag_valid)
  );

  always #5 CLK = ~CLK;

  assign obs = {ready, busy, st_load, rnd_en, rnd_idx, key_xor_init, ad_xor,
                dom_sep, pt_xor, c_valid, key_xor_fin, tag_valid};

  localparam logic [14:0] IDLE_V = 15'h4000;

  // Expected output vector for cycle c of an operation with AD (start at edge 0).
  function automatic logic [14:0] sched(input int c);
    logic [14:0] v;
    v = 15'h2000;
    if (c <= 0 || c >= 38)       v = IDLE_V;
    else if (c == 1)             v[12] = 1'b1;
    else if (c <= 13)            begin v[11] = 1'b1; v[10:7] = 4'(c - 2);  end
    else if (c == 14)            v[6] = 1'b1;
    else if (c == 15)            v[5] = 1'b1;
    else if (c <= 21)            begin v[11] = 1'b1; v[10:7] = 4'(c - 10); end
    else if (c == 22)            v[4] = 1'b1;
    else if (c == 23)            begin v[3] = 1'b1; v[2] = 1'b1; end
    else if (c == 24)            v[1] = 1'b1;
    else if (c <= 36)            begin v[11] = 1'b1; v[10:7] = 4'(c - 25); end
    else                         v[0] = 1'b1;
    return v;
  endfunction

  // Without AD the schedule after INIT_KEY is the AD schedule shifted by 7.
  function automatic logic [14:0] sched_nad(input int c);
    return (c >= 15) ? sched(c + 7) : sched(c);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    // Reset held for two edges
    RST = 1'b1;
    tick(); tick();
    chk("reset_vec", 32'(obs), 32'(IDLE_V));
    chk("reset_rnd_idx", 32'(rnd_idx), 32'd0);
    RST = 1'b0;
    tick();
    chk("idle_hold", 32'(obs), 32'(IDLE_V));

    chk("rc_0", 32'(round_const(4'd0)), 32'h0F0);
    chk("rc_6", 32'(round_const(4'd6)), 32'h096);
    chk("rc_11", 32'(round_const(4'd11)), 32'h04B);

    // Operation with AD, out_ack tied high
    out_ack = 1'b1; has_ad = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; has_ad = 1'b0;
    n_rnd = 0;
    for (int c = 1; c <= 38; c++) begin
      chk($sformatf("ad_cyc%0d", c), 32'(obs), 32'(sched(c)));
      if (rnd_en) n_rnd++;
      if (c < 38) tick();
    end
    chk("ad_rnd_count", 32'(n_rnd), 32'd30);

    // Operation without AD
    has_ad = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; has_ad = 1'b1;
    n_rnd = 0; n_ad = 0;
    for (int c = 1; c <= 31; c++) begin
      chk($sformatf("nad_cyc%0d", c), 32'(obs), 32'(sched_nad(c)));
      if (rnd_en) n_rnd++;
      if (ad_xor) n_ad++;
      if (c < 31) tick();
    end
    chk("nad_rnd_count", 32'(n_rnd), 32'd24);
    chk("nad_ad_xor_count", 32'(n_ad), 32'd0);

    // Tag held without acknowledge, start pulses ignored
    out_ack = 1'b0; has_ad = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 30; c++) tick();
    chk("tag_enter", 32'(obs), 32'(sched_nad(30)));
    for (int k = 0; k < 20; k++) begin
      start = k[0];
      tick();
      chk($sformatf("tag_hold%0d", k), 32'(obs), 32'(sched_nad(30)));
    end
    start = 1'b1; out_ack = 1'b1;
    tick();
    start = 1'b0;
    chk("tag_ack_idle", 32'(obs), 32'(IDLE_V));
    tick();
    chk("no_restart", 32'(obs), 32'(IDLE_V));

    // Reset in cycle 20 of an AD operation
    has_ad = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("pre_rst_cyc20", 32'(obs), 32'(sched(20)));
    RST = 1'b1;
    tick();
    chk("mid_rst_idle", 32'(obs), 32'(IDLE_V));
    RST = 1'b0;
    n_cv = 0; n_tv = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (c_valid) n_cv++;
      if (tag_valid) n_tv++;
    end
    chk("rst_no_c_valid", 32'(n_cv), 32'd0);
    chk("rst_no_tag_valid", 32'(n_tv), 32'd0);
    chk("rst_still_idle", 32'(obs), 32'(IDLE_V));
    RST = 1'b1; start = 1'b1;
    tick();
    RST = 1'b0; start = 1'b0;
    chk("rst_beats_start", 32'(obs), 32'(IDLE_V));
    has_ad = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 38; c++) begin
      if (c == 1 || c == 23 || c == 37 || c == 38)
        chk($sformatf("post_rst_cyc%0d", c), 32'(obs), 32'(sched(c)));
      if (c < 38) tick();
    end

    // Back-to-back with start held high
    has_ad = 1'b0; out_ack = 1'b1; start = 1'b1;
    tick();
    n_ld = 0;
    for (int c = 1; c <= 61; c++) begin
      chk($sformatf("b2b_cyc%0d", c), 32'(obs),
          32'((c <= 31) ? sched_nad(c) : sched_nad(c - 31)));
      if (st_load) n_ld++;
      if (c < 61) tick();
    end
    chk("b2b_st_load_count", 32'(n_ld), 32'd2);
    start = 1'b0;
    tick();
    chk("b2b_final_idle", 32'(obs), 32'(IDLE_V));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
